// File: rtl/ecc_pkg.sv
// Shared constants and a reference modular-add function for the ECC datapath.
package ecc_pkg;

    localparam int unsigned ECC_LEN_DEFAULT = 8;
    localparam int unsigned ECC_LEN_MAX     = 32;

    // Width-generic (a + b) mod p at `len` bits using the same carry-preserving recipe as the datapath.
    function automatic logic [ECC_LEN_MAX-1:0] mod_add_f(
        input logic [ECC_LEN_MAX-1:0] a,
        input logic [ECC_LEN_MAX-1:0] b,
        input logic [ECC_LEN_MAX-1:0] p,
        input int unsigned            len
    );
        logic [ECC_LEN_MAX:0]   mask;
        logic [ECC_LEN_MAX:0]   sum;
        logic [ECC_LEN_MAX:0]   diff;
        logic [ECC_LEN_MAX:0]   res;
        mask = ({1'b0, {ECC_LEN_MAX{1'b1}}} >> (ECC_LEN_MAX - len));
        sum  = ({1'b0, a} & mask) + ({1'b0, b} & mask);
        diff = sum - ({1'b0, p} & mask);
        res  = (sum >= ({1'b0, p} & mask)) ? diff : sum;
        return res[ECC_LEN_MAX-1:0] & mask[ECC_LEN_MAX-1:0];
    endfunction

endpackage

// File: rtl/ecc_mod_add_if.sv
// Operand/result bundle for the registered modular adder.
interface ecc_mod_add_if #(
    parameter int unsigned LEN = 8
);
    logic           in_valid;
    logic [LEN-1:0] a;
    logic [LEN-1:0] b;
    logic [LEN-1:0] p;
    logic           out_valid;
    logic [LEN-1:0] c;
    logic           range_err;

    modport master (
        output in_valid, a, b, p,
        input  out_valid, c, range_err
    );

    modport slave (
        input  in_valid, a, b, p,
        output out_valid, c, range_err
    );
endinterface

// File: rtl/ecc_mod_add_core.sv
// Combinational sum/compare/subtract/select for c = (a + b) mod p, plus operand range check.
module ecc_mod_add_core
    import ecc_pkg::*;
#(
    parameter int unsigned LEN = ECC_LEN_DEFAULT
) (
    input  logic [LEN-1:0] a,
    input  logic [LEN-1:0] b,
    input  logic [LEN-1:0] p,
    output logic [LEN-1:0] c_next,
    output logic           err_next
);
    logic [LEN:0] sum;
    logic [LEN:0] diff;
    logic         ge;
    logic         p_small;

    // Sum kept at LEN+1 bits so the carry participates in the compare and subtract.
    always_comb begin
        sum      = {1'b0, a} + {1'b0, b};
        diff     = sum - {1'b0, p};
        ge       = (sum >= {1'b0, p});
        c_next   = ge ? diff[LEN-1:0] : sum[LEN-1:0];
        p_small  = ~|p[LEN-1:1];
        err_next = (a >= p) | (b >= p) | p_small;
    end
endmodule

// File: rtl/ecc_mod_add.sv
// Registered modular adder: one-cycle latency, one op per cycle, no backpressure.
module ecc_mod_add
    import ecc_pkg::*;
#(
    parameter int unsigned LEN = ECC_LEN_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    ecc_mod_add_if.slave bus
);
    logic [LEN-1:0] c_next;
    logic           err_next;
    logic [LEN-1:0] c_q;
    logic           err_q;
    logic           valid_q;

    ecc_mod_add_core #(
        .LEN(LEN)
    ) u_core (
        .a        (bus.a),
        .b        (bus.b),
        .p        (bus.p),
        .c_next   (c_next),
        .err_next (err_next)
    );

    // Result and error hold across idle cycles; only the valid strobe tracks in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q     <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                c_q   <= c_next;
                err_q <= err_next;
            end
        end
    end

    assign bus.c         = c_q;
    assign bus.range_err = err_q;
    assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_ecc_mod_add.sv
// Directed and random checks for the registered modular adder at LEN=8.
module tb_ecc_mod_add;
    import ecc_pkg::*;

    localparam int unsigned LEN = 8;

    typedef struct {
        int unsigned a;
        int unsigned b;
        int unsigned p;
        int unsigned c;
        bit          err;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    ecc_mod_add_if #(.LEN(LEN)) bus ();

    ecc_mod_add #(
        .LEN(LEN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int unsigned a, input int unsigned b, input int unsigned p);
        bus.in_valid = 1'b1;
        bus.a        = a[LEN-1:0];
        bus.b        = b[LEN-1:0];
        bus.p        = p[LEN-1:0];
    endtask

    vec_t vecs[12];
    int unsigned held_c;

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.p        = '0;

        vecs[0]  = '{78, 31, 113, 109, 1'b0};
        vecs[1]  = '{28, 37, 47, 18, 1'b0};
        vecs[2]  = '{250, 250, 251, 249, 1'b0};
        vecs[3]  = '{112, 112, 113, 111, 1'b0};
        vecs[4]  = '{40, 7, 47, 0, 1'b0};
        vecs[5]  = '{0, 0, 47, 0, 1'b0};
        vecs[6]  = '{50, 1, 47, 4, 1'b1};
        vecs[7]  = '{200, 100, 0, 44, 1'b1};
        vecs[8]  = '{99, 99, 100, 98, 1'b0};
        vecs[9]  = '{254, 254, 255, 253, 1'b0};
        vecs[10] = '{0, 0, 1, 0, 1'b1};
        vecs[11] = '{255, 255, 255, 255, 1'b1};

        #12;
        check("reset_c", 32'(bus.c), 0);
        check("reset_out_valid", 32'(bus.out_valid), 0);
        check("reset_range_err", 32'(bus.range_err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: one op, check pulse, then one idle cycle
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(vecs[i].a, vecs[i].b, vecs[i].p);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 1);
            check($sformatf("vec%0d_c", i), 32'(bus.c), vecs[i].c);
            check($sformatf("vec%0d_err", i), 32'(bus.range_err), 32'(vecs[i].err));
            @(negedge clk);
            bus.in_valid = 1'b0;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_idle_valid", i), 32'(bus.out_valid), 0);
            check($sformatf("vec%0d_idle_c", i), 32'(bus.c), vecs[i].c);
            check($sformatf("vec%0d_idle_err", i), 32'(bus.range_err), 32'(vecs[i].err));
        end

        // Back-to-back: three consecutive ops give three consecutive results
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(vecs[i].a, vecs[i].b, vecs[i].p);
            @(posedge clk);
            #1;
            check($sformatf("b2b%0d_valid", i), 32'(bus.out_valid), 1);
            check($sformatf("b2b%0d_c", i), 32'(bus.c), vecs[i].c);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        held_c = vecs[2].c;
        @(posedge clk);
        #1;
        check("b2b_idle_valid", 32'(bus.out_valid), 0);
        check("b2b_idle_c", 32'(bus.c), held_c);

        // Reset mid-stream clears the pending result without waiting for a clock
        @(negedge clk);
        drive(78, 31, 113);
        @(posedge clk);
        #1;
        check("pre_rst_valid", 32'(bus.out_valid), 1);
        check("pre_rst_c", 32'(bus.c), 109);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(bus.out_valid), 0);
        check("async_rst_c", 32'(bus.c), 0);
        check("async_rst_err", 32'(bus.range_err), 0);
        @(posedge clk);
        #1;
        check("held_rst_valid", 32'(bus.out_valid), 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;

        // Random streaming sweep over reduced operands
        for (int i = 0; i < 10000; i++) begin
            int unsigned p;
            int unsigned a;
            int unsigned b;
            int unsigned exp_c;
            p = $urandom_range(255, 2);
            a = $urandom_range(p - 1, 0);
            b = $urandom_range(p - 1, 0);
            exp_c = (a + b) % p;
            @(negedge clk);
            drive(a, b, p);
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b1 || 32'(bus.c) !== exp_c || bus.range_err !== 1'b0)
                check($sformatf("sweep%0d_a%0d_b%0d_p%0d", i, a, b, p),
                      {bus.out_valid, bus.range_err, 22'd0, bus.c}, {2'b10, 22'd0, exp_c[7:0]});
            else
                check("sweep_ref", 32'(bus.c), mod_add_f(a, b, p, LEN));
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("final_idle_valid", 32'(bus.out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
